delay_pipe: RTL and testbench
=============================

Name: delay_pipe

Overview:
- Parametrised successor to the fixed delay line: a DELAY-stage pipeline register carrying data plus a per-stage valid tag.
- Adds stall (hold), flush (kill in-flight entries), bubble tracking and an in-flight occupancy counter.
- Used to align side-band data with multi-cycle datapath stages, e.g. the pipeline and the MUL/DIV and load paths, which need stall/flush coherency.

Parameters:
WIDTH, 1, data width in bits (>=1)
DELAY, 1, number of register stages (>=0; 0 = combinational pass-through)
DEFAULT, 0, data value loaded on reset, into bubble slots, and on flush when FLUSH_DATA=1
FLUSH_DATA, 1, 1: flush also resets stage data to DEFAULT; 0: flush clears valids only, data retained

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold all stages; input ignored
flush  input  1  invalidate all in-flight entries; input on this cycle discarded
in_valid  input  1  din carries a real entry this cycle
din  input  WIDTH  input data
out_valid  output  1  valid tag of oldest stage
dout  output  WIDTH  data of oldest stage
inflight  output  CW  count of valid stages, CW = max(1, $clog2(DELAY+1))
empty  output  1  inflight == 0

Behaviour:
- Stages s[0..DELAY-1], each {v, d}. s[DELAY-1] is the entry stage; s[0] drives out_valid/dout directly (registered outputs, no comb path from inputs when DELAY>=1).
- Priority per edge: rst > flush > stall > advance.
- rst: all v=0, all d=DEFAULT, inflight=0. Takes effect mid-stream, discarding everything.
- flush (rst=0): all v=0, inflight=0. If FLUSH_DATA=1, all d=DEFAULT; else d held. in_valid/din on the flush cycle are dropped. Flush with stall=1 still flushes.
- stall (rst=0, flush=0): all stages and inflight hold; in_valid/din ignored (the upstream holds its entry).
- advance: s[i] <= s[i+1] for i<DELAY-1. s[DELAY-1] <= {in_valid, in_valid ? din : DEFAULT}. Bubbles therefore carry DEFAULT.
- Latency: an entry accepted on an advancing edge appears on out_valid/dout after DELAY advancing edges; stalled cycles do not count.
- Output is not back-pressured: s[0] is overwritten on each advance whether or not it was consumed.
- inflight: registered popcount of next-state v bits. On advance, next = inflight + in_valid - s[0].v, with no overflow since it is bounded by DELAY. Must equal the popcount of v at all times (assertion).
- empty: combinational from inflight.
- DELAY=0: out_valid = in_valid, dout = din, combinationally. stall, flush and rst have no effect on the data path; inflight=0, empty=1 constantly.
- DELAY=1: single stage; all rules above apply with s[0] as both the entry and output stage.
- No X on outputs after the first reset edge.

Test Plan:
- Reset (WIDTH=8, DELAY=3, DEFAULT=8'hA5): assert rst 2 cycles -> out_valid=0, dout=8'hA5, inflight=0, empty=1.
- Stream: in_valid=1 with din 8'h01, 8'h02, 8'h03 on edges 1-3, then idle -> inflight 1,2,3 after edges 1-3. out_valid=1 with dout 01/02/03 after edges 3/4/5, dout=A5 after edge 6, inflight 0 after edge 6.
- Stall: push 8'h10 on edge 1, stall=1 over edges 2-3 -> 8'h10 appears after edge 5. inflight stays 1 during stall; din presented while stalled is not captured.
- Flush: two entries 8'h20, 8'h21 in flight plus in_valid=1 din=8'h22 with flush=1 and stall=1 -> after the edge out_valid=0, dout=A5, inflight=0. Nothing emerges on the next 3 edges. Repeat with FLUSH_DATA=0 -> valids cleared, data retained.
- Bubbles and mid-stream reset: pattern valid/invalid/valid (8'h30, x, 8'h31) -> outputs 30, A5 (out_valid=0), 31 in consecutive cycles. rst asserted when 2 entries are in flight -> all cleared on the next edge.
- Corners: DELAY=0 -> dout follows din in the same cycle, stall/flush ignored. DELAY=1 -> 1-cycle latency, inflight toggles 0/1. Random stall/flush/in_valid (10k cycles) against a scoreboard, with the inflight == popcount assertion.

Source files
------------

// File: rtl/delay_pipe_if.sv
// Upstream/downstream bundle for delay_pipe: per-cycle control and data in,
// oldest-stage tag/data and occupancy out.
interface delay_pipe_if #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
);
  localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

  // Handshake: in_valid/din are sampled only on an advancing edge (no rst,
  // no flush, no stall); there is no ready, the producer holds its entry
  // while stall is high. out_valid/dout are not back-pressured and change
  // on every advancing edge whether or not the consumer took them.
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    inflight;
  logic             empty;

  modport master (
    output stall, flush, in_valid, din,
    input  out_valid, dout, inflight, empty
  );

  modport slave (
    input  stall, flush, in_valid, din,
    output out_valid, dout, inflight, empty
  );
endinterface

// File: rtl/delay_pipe.sv
// DELAY-stage data+valid pipeline with stall, flush, bubble tracking and a
// registered in-flight occupancy counter.
module delay_pipe #(
  parameter int               WIDTH      = 1,
  parameter int               DELAY      = 1,
  parameter logic [WIDTH-1:0] DEFAULT    = '0,
  parameter int               FLUSH_DATA = 1
) (
  input logic         clk,
  input logic         rst,
  delay_pipe_if.slave bus
);
  localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

  generate
    if (DELAY == 0) begin : g_pass
      assign bus.out_valid = bus.in_valid;
      assign bus.dout      = bus.din;
      assign bus.inflight  = '0;
      assign bus.empty     = 1'b1;
    end else begin : g_pipe
      // Stage 0 is the output stage, stage DELAY-1 the entry stage.
      logic [DELAY-1:0] v_q, v_d;
      logic [WIDTH-1:0] d_q [DELAY];
      logic [WIDTH-1:0] d_d [DELAY];
      logic [CW-1:0]    cnt_q, cnt_d;

      always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
          v_d   = '0;
          cnt_d = '0;
          if (FLUSH_DATA != 0) begin
            for (int i = 0; i < DELAY; i++) d_d[i] = DEFAULT;
          end
        end else if (!bus.stall) begin
          for (int i = 0; i < DELAY - 1; i++) begin
            v_d[i] = v_q[i+1];
            d_d[i] = d_q[i+1];
          end
          v_d[DELAY-1] = bus.in_valid;
          d_d[DELAY-1] = bus.in_valid ? bus.din : DEFAULT;
          // Bounded by DELAY, so the modular add/sub never wraps in practice.
          cnt_d = cnt_q + CW'(bus.in_valid) - CW'(v_q[0]);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= '0;
          cnt_q <= '0;
          for (int i = 0; i < DELAY; i++) d_q[i] <= DEFAULT;
        end else begin
          v_q   <= v_d;
          cnt_q <= cnt_d;
          for (int i = 0; i < DELAY; i++) d_q[i] <= d_d[i];
        end
      end

      assign bus.out_valid = v_q[0];
      assign bus.dout      = d_q[0];
      assign bus.inflight  = cnt_q;
      assign bus.empty     = (cnt_q == '0);

      a_inflight_popcount : assert property (
        @(posedge clk) disable iff (rst) int'(cnt_q) == $countones(v_q)
      );
    end
  endgenerate
endmodule

// File: tb/tb_delay_pipe.sv
// Directed and randomized checks for delay_pipe across DELAY=3 (both flush
// data modes), DELAY=0 and DELAY=1, all driven from one stimulus stream.
module tb_delay_pipe;
  localparam logic [7:0] DEF = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Expected queue for the DELAY=3 pipe: front is stage 0, {v, d}.
  logic [8:0] exp_q[$];
  logic [8:0] exp_d1;

  delay_pipe_if #(.WIDTH(8), .DELAY(3)) ifa ();
  delay_pipe_if #(.WIDTH(8), .DELAY(3)) ifb ();
  delay_pipe_if #(.WIDTH(8), .DELAY(0)) ifc ();
  delay_pipe_if #(.WIDTH(8), .DELAY(1)) ifd ();

  assign ifb.stall = ifa.stall;  assign ifb.flush = ifa.flush;
  assign ifb.in_valid = ifa.in_valid;  assign ifb.din = ifa.din;
  assign ifc.stall = ifa.stall;  assign ifc.flush = ifa.flush;
  assign ifc.in_valid = ifa.in_valid;  assign ifc.din = ifa.din;
  assign ifd.stall = ifa.stall;  assign ifd.flush = ifa.flush;
  assign ifd.in_valid = ifa.in_valid;  assign ifd.din = ifa.din;

  delay_pipe #(.WIDTH(8), .DELAY(3), .DEFAULT(DEF), .FLUSH_DATA(1))
    u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  delay_pipe #(.WIDTH(8), .DELAY(3), .DEFAULT(DEF), .FLUSH_DATA(0))
    u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  delay_pipe #(.WIDTH(8), .DELAY(0), .DEFAULT(DEF), .FLUSH_DATA(1))
    u_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  delay_pipe #(.WIDTH(8), .DELAY(1), .DEFAULT(DEF), .FLUSH_DATA(1))
    u_d (.clk(clk), .rst(rst), .bus(ifd.slave));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [7:0] d,
                       input logic s, input logic f);
    ifa.in_valid = v;
    ifa.din      = d;
    ifa.stall    = s;
    ifa.flush    = f;
  endtask

  // ---------------- checker / scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, DEF});
    exp_d1 = {1'b0, DEF};
  endtask

  task automatic model_step(input logic r, input logic f, input logic s,
                            input logic v, input logic [7:0] d);
    if (r || f) begin
      clear_model();
    end else if (!s) begin
      void'(exp_q.pop_front());
      exp_q.push_back(v ? {1'b1, d} : {1'b0, DEF});
      exp_d1 = v ? {1'b1, d} : {1'b0, DEF};
    end
  endtask

  function automatic logic [31:0] exp_a();
    int cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) cnt += int'(exp_q[i][8]);
    return 32'({exp_q[0][8], exp_q[0][7:0], 2'(cnt), (cnt == 0)});
  endfunction

  function automatic logic [31:0] exp_d();
    return 32'({exp_d1[8], exp_d1[7:0], exp_d1[8], ~exp_d1[8]});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic r_rst, r_f, r_s, r_v;
    logic [7:0] r_d;

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    check("rst_a_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_a_dout", 32'(ifa.dout), 32'(DEF));
    check("rst_a_inflight", 32'(ifa.inflight), 32'd0);
    check("rst_a_empty", 32'(ifa.empty), 32'd1);
    check("rst_d_dout", 32'(ifd.dout), 32'(DEF));
    check("rst_d_inflight", 32'(ifd.inflight), 32'd0);
    rst = 1'b0;

    // Stream of three entries, then idle.
    drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
    check("str_inf1", 32'(ifa.inflight), 32'd1);
    check("str_d1", 32'({ifd.out_valid, ifd.dout, ifd.inflight}), 32'({1'b1, 8'h01, 1'b1}));
    drive(1'b1, 8'h02, 1'b0, 1'b0); tick();
    check("str_inf2", 32'(ifa.inflight), 32'd2);
    check("str_v_early", 32'(ifa.out_valid), 32'd0);
    drive(1'b1, 8'h03, 1'b0, 1'b0); tick();
    check("str_inf3", 32'(ifa.inflight), 32'd3);
    check("str_out1", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h01}));
    drive(1'b0, 8'hEE, 1'b0, 1'b0); tick();
    check("str_out2", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h02}));
    check("str_inf4", 32'(ifa.inflight), 32'd2);
    check("str_d_idle", 32'({ifd.out_valid, ifd.dout, ifd.inflight}), 32'({1'b0, DEF, 1'b0}));
    tick();
    check("str_out3", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h03}));
    tick();
    check("str_out_idle", 32'({ifa.out_valid, ifa.dout}), 32'({1'b0, DEF}));
    check("str_inf6", 32'(ifa.inflight), 32'd0);
    check("str_empty6", 32'(ifa.empty), 32'd1);

    // Stall holds everything; data offered while stalled is dropped.
    drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h55, 1'b1, 1'b0); tick();
    check("stl_inf2", 32'(ifa.inflight), 32'd1);
    check("stl_v2", 32'(ifa.out_valid), 32'd0);
    tick();
    check("stl_inf3", 32'(ifa.inflight), 32'd1);
    check("stl_d_hold", 32'({ifd.out_valid, ifd.dout}), 32'({1'b1, 8'h10}));
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("stl_v4", 32'(ifa.out_valid), 32'd0);
    tick();
    check("stl_out5", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h10}));
    tick();
    check("stl_inf6", 32'(ifa.inflight), 32'd0);
    check("stl_v6", 32'(ifa.out_valid), 32'd0);

    // Flush with stall and a new entry on the same edge.
    drive(1'b1, 8'h20, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h21, 1'b0, 1'b0); tick();
    check("fl_pre_inf", 32'(ifa.inflight), 32'd2);
    drive(1'b1, 8'h22, 1'b1, 1'b1); tick();
    check("fl_a_out", 32'({ifa.out_valid, ifa.dout}), 32'({1'b0, DEF}));
    check("fl_a_inf", 32'({ifa.inflight, ifa.empty}), 32'({2'd0, 1'b1}));
    check("fl_b_inf", 32'({ifb.out_valid, ifb.inflight}), 32'd0);
    check("fl_d_out", 32'({ifd.out_valid, ifd.dout, ifd.inflight}), 32'({1'b0, DEF, 1'b0}));
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("fl1_a", 32'({ifa.out_valid, ifa.dout, ifa.inflight}), 32'({1'b0, DEF, 2'd0}));
    check("fl1_b_keep", 32'({ifb.out_valid, ifb.dout}), 32'({1'b0, 8'h20}));
    tick();
    check("fl2_a", 32'({ifa.out_valid, ifa.dout}), 32'({1'b0, DEF}));
    check("fl2_b_keep", 32'({ifb.out_valid, ifb.dout}), 32'({1'b0, 8'h21}));
    tick();
    check("fl3_a", 32'({ifa.out_valid, ifa.dout, ifa.inflight}), 32'({1'b0, DEF, 2'd0}));
    check("fl3_b", 32'({ifb.out_valid, ifb.dout}), 32'({1'b0, DEF}));

    // Bubble between two entries carries DEFAULT, not the idle din.
    drive(1'b1, 8'h30, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h31, 1'b0, 1'b0); tick();
    check("bub_out30", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h30}));
    check("bub_d31", 32'({ifd.out_valid, ifd.dout}), 32'({1'b1, 8'h31}));
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("bub_hole", 32'({ifa.out_valid, ifa.dout, ifa.inflight}), 32'({1'b0, DEF, 2'd1}));
    tick();
    check("bub_out31", 32'({ifa.out_valid, ifa.dout}), 32'({1'b1, 8'h31}));

    // Reset with two entries in flight.
    drive(1'b1, 8'h40, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h41, 1'b0, 1'b0); tick();
    check("mrst_pre", 32'(ifa.inflight), 32'd2);
    rst = 1'b1;
    drive(1'b1, 8'h42, 1'b0, 1'b0); tick();
    check("mrst_a", 32'({ifa.out_valid, ifa.dout, ifa.inflight, ifa.empty}),
          32'({1'b0, DEF, 2'd0, 1'b1}));
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_drain", 32'({ifa.out_valid, ifa.inflight}), 32'd0);
    end

    // DELAY=1 toggling occupancy.
    drive(1'b1, 8'h61, 1'b0, 1'b0); tick();
    check("d1_a", 32'({ifd.out_valid, ifd.dout, ifd.inflight, ifd.empty}), 32'({1'b1, 8'h61, 1'b1, 1'b0}));
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("d1_b", 32'({ifd.out_valid, ifd.dout, ifd.inflight, ifd.empty}), 32'({1'b0, DEF, 1'b0, 1'b1}));
    drive(1'b1, 8'h62, 1'b0, 1'b0); tick();
    check("d1_c", 32'({ifd.out_valid, ifd.dout, ifd.inflight}), 32'({1'b1, 8'h62, 1'b1}));

    // DELAY=0 is a wire regardless of stall/flush/rst.
    drive(1'b1, 8'h5A, 1'b1, 1'b1); #1;
    check("d0_a", 32'({ifc.out_valid, ifc.dout, ifc.inflight, ifc.empty}), 32'({1'b1, 8'h5A, 1'b0, 1'b1}));
    rst = 1'b1;
    drive(1'b0, 8'h3C, 1'b0, 1'b1); #1;
    check("d0_b", 32'({ifc.out_valid, ifc.dout, ifc.inflight, ifc.empty}), 32'({1'b0, 8'h3C, 1'b0, 1'b1}));

    // Random control against the expected-queue model.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    clear_model();
    rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      r_rst = ($urandom_range(0, 255) == 0);
      r_f   = ($urandom_range(0, 15) == 0);
      r_s   = ($urandom_range(0, 3) == 0);
      r_v   = ($urandom_range(0, 1) == 1);
      r_d   = 8'($urandom_range(0, 255));
      rst   = r_rst;
      drive(r_v, r_d, r_s, r_f);
      model_step(r_rst, r_f, r_s, r_v, r_d);
      tick();
      check("rand_a", 32'({ifa.out_valid, ifa.dout, ifa.inflight, ifa.empty}), exp_a());
      check("rand_d", 32'({ifd.out_valid, ifd.dout, ifd.inflight, ifd.empty}), exp_d());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
